// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS two-port to one-port Avalon-MM bus arbiter.
package mips_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BUS_I  = 3'd1,
      ST_BUS_D  = 3'd2,
      ST_RESP_I = 3'd3,
      ST_RESP_D = 3'd4
   } arb_state_t;

   localparam logic [3:0] BE_WORD    = 4'hF;
   localparam logic       PORT_INSTR = 1'b0;
   localparam logic       PORT_DATA  = 1'b1;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall watchdog: counts stalled bus cycles of the current transaction, saturates,
// and raises a sticky flag once the limit is reached.
module mips_bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic stall,
   output logic timeout
);
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (clear) begin
         cnt_d = '0;
      end else if (stall) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
         if (32'(cnt_d) >= TIMEOUT_CYCLES) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the MIPS instruction-fetch
// and data ports; one transaction at a time with registered bus outputs.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter bit          DATA_FIRST     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [3:0]  d_byteenable,
   input  logic [31:0] d_writedata,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        bus_timeout,
   output logic        protocol_error
);
   arb_state_t  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] address_q, address_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [3:0]  byteenable_q, byteenable_d;
   logic [31:0] writedata_q, writedata_d;
   logic [31:0] i_readdata_q, i_readdata_d;
   logic [31:0] d_readdata_q, d_readdata_d;
   logic        busy_q, busy_d;
   logic        protocol_error_q, protocol_error_d;
   logic        grant_data_c;
   logic        d_req_c;
   logic        wd_clear_c;
   logic        wd_stall_c;

   assign d_req_c = d_read | d_write;

   // Next-state, arbitration and bus-register update
   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      address_d        = address_q;
      read_d           = read_q;
      write_d          = write_q;
      byteenable_d     = byteenable_q;
      writedata_d      = writedata_q;
      i_readdata_d     = i_readdata_q;
      d_readdata_d     = d_readdata_q;
      protocol_error_d = protocol_error_q;
      grant_data_c     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (d_read && d_write) protocol_error_d = 1'b1;
            if (i_read || d_req_c) begin
               if (i_read && d_req_c) grant_data_c = (last_grant_q == PORT_INSTR);
               else                   grant_data_c = d_req_c;
               if (grant_data_c) begin
                  state_d      = ST_BUS_D;
                  last_grant_d = PORT_DATA;
                  address_d    = d_address;
                  read_d       = d_read & ~d_write;
                  write_d      = d_write;
                  byteenable_d = d_byteenable;
                  writedata_d  = d_writedata;
               end else begin
                  state_d      = ST_BUS_I;
                  last_grant_d = PORT_INSTR;
                  address_d    = i_address;
                  read_d       = 1'b1;
                  write_d      = 1'b0;
                  byteenable_d = BE_WORD;
                  writedata_d  = '0;
               end
            end
         end
         ST_BUS_I: begin
            if (!waitrequest) begin
               read_d       = 1'b0;
               i_readdata_d = readdata;
               state_d      = ST_RESP_I;
            end
         end
         ST_BUS_D: begin
            if (!waitrequest) begin
               if (read_q) d_readdata_d = readdata;
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = ST_RESP_D;
            end
         end
         ST_RESP_I, ST_RESP_D: state_d = ST_IDLE;
         default:              state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         last_grant_q     <= ~DATA_FIRST;
         address_q        <= '0;
         read_q           <= 1'b0;
         write_q          <= 1'b0;
         byteenable_q     <= '0;
         writedata_q      <= '0;
         i_readdata_q     <= '0;
         d_readdata_q     <= '0;
         busy_q           <= 1'b0;
         protocol_error_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         address_q        <= address_d;
         read_q           <= read_d;
         write_q          <= write_d;
         byteenable_q     <= byteenable_d;
         writedata_q      <= writedata_d;
         i_readdata_q     <= i_readdata_d;
         d_readdata_q     <= d_readdata_d;
         busy_q           <= busy_d;
         protocol_error_q <= protocol_error_d;
      end
   end

   // Counter restarts on each grant; only stalled bus-phase cycles count
   assign wd_clear_c = (state_q == ST_IDLE) && (state_d != ST_IDLE);
   assign wd_stall_c = ((state_q == ST_BUS_I) || (state_q == ST_BUS_D)) && waitrequest;

   mips_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear_c),
      .stall   (wd_stall_c),
      .timeout (bus_timeout)
   );

   assign i_waitrequest  = i_read  & ~(state_q == ST_RESP_I);
   assign d_waitrequest  = d_req_c & ~(state_q == ST_RESP_D);
   assign i_readdata     = i_readdata_q;
   assign d_readdata     = d_readdata_q;
   assign address        = address_q;
   assign read           = read_q;
   assign write          = write_q;
   assign byteenable     = byteenable_q;
   assign writedata      = writedata_q;
   assign busy           = busy_q;
   assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter (DATA_FIRST=1, TIMEOUT_CYCLES=8).
module tb_mips_bus_arbiter;
   logic        clk;
   logic        reset;
   logic        i_read;
   logic [31:0] i_address;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [3:0]  d_byteenable;
   logic [31:0] d_writedata;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        busy;
   logic        bus_timeout;
   logic        protocol_error;

   int n_cmp = 0;
   int n_bad = 0;

   mips_bus_arbiter #(
      .DATA_FIRST     (1'b1),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_read         (i_read),
      .i_address      (i_address),
      .i_waitrequest  (i_waitrequest),
      .i_readdata     (i_readdata),
      .d_read         (d_read),
      .d_write        (d_write),
      .d_address      (d_address),
      .d_byteenable   (d_byteenable),
      .d_writedata    (d_writedata),
      .d_waitrequest  (d_waitrequest),
      .d_readdata     (d_readdata),
      .address        (address),
      .read           (read),
      .write          (write),
      .byteenable     (byteenable),
      .writedata      (writedata),
      .waitrequest    (waitrequest),
      .readdata       (readdata),
      .busy           (busy),
      .bus_timeout    (bus_timeout),
      .protocol_error (protocol_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_byteenable = '0; d_writedata = '0;
      waitrequest = 1'b0; readdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      settle();
      check_eq("rst_read",   32'(read), 32'd0);
      check_eq("rst_write",  32'(write), 32'd0);
      check_eq("rst_addr",   address, 32'd0);
      check_eq("rst_be",     32'(byteenable), 32'd0);
      check_eq("rst_busy",   32'(busy), 32'd0);
      check_eq("rst_flags",  {30'd0, bus_timeout, protocol_error}, 32'd0);
      check_eq("rst_rdata",  i_readdata | d_readdata, 32'd0);

      // Zero-wait instruction fetch
      cyc(); reset = 1'b0;
      i_read = 1'b1; i_address = 32'hBFC00000; readdata = 32'h3C010001; settle();
      check_eq("t1_c0_iwait", 32'(i_waitrequest), 32'd1);
      cyc(); settle();
      check_eq("t1_c1_read", 32'(read), 32'd1);
      check_eq("t1_c1_addr", address, 32'hBFC00000);
      check_eq("t1_c1_be",   32'(byteenable), 32'hF);
      check_eq("t1_c1_iwait", 32'(i_waitrequest), 32'd1);
      cyc(); settle();
      check_eq("t1_c2_iwait", 32'(i_waitrequest), 32'd0);
      check_eq("t1_c2_rdata", i_readdata, 32'h3C010001);
      check_eq("t1_c2_read",  32'(read), 32'd0);
      i_read = 1'b0;
      cyc(); settle();
      check_eq("t1_c3_busy", 32'(busy), 32'd0);

      // Contention right after reset: data first, then instruction
      do_reset();
      i_read = 1'b1; i_address = 32'h00000100;
      d_read = 1'b1; d_address = 32'h00002000; d_byteenable = 4'hF;
      readdata = 32'h11111111; settle();
      check_eq("t2_c0_waits", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
      cyc(); settle();
      check_eq("t2_c1_addr", address, 32'h00002000);
      check_eq("t2_c1_read", 32'(read), 32'd1);
      cyc(); settle();
      check_eq("t2_c2_waits", {30'd0, i_waitrequest, d_waitrequest}, 32'd2);
      check_eq("t2_c2_drdata", d_readdata, 32'h11111111);
      d_read = 1'b0; readdata = 32'h22222222;
      cyc(); settle();
      check_eq("t2_c3_iwait", 32'(i_waitrequest), 32'd1);
      check_eq("t2_c3_read",  32'(read), 32'd0);
      cyc(); settle();
      check_eq("t2_c4_addr",  address, 32'h00000100);
      check_eq("t2_c4_iwait", 32'(i_waitrequest), 32'd1);
      cyc(); settle();
      check_eq("t2_c5_iwait",  32'(i_waitrequest), 32'd0);
      check_eq("t2_c5_irdata", i_readdata, 32'h22222222);
      check_eq("t2_c5_drdata", d_readdata, 32'h11111111);
      i_read = 1'b0;
      cyc(); settle();

      // Write with four wait states
      d_write = 1'b1; d_address = 32'h00001000; d_byteenable = 4'b0011;
      d_writedata = 32'hAABBCCDD; waitrequest = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         if (k == 5) waitrequest = 1'b0;
         settle();
         check_eq($sformatf("t3_c%0d_write", k), 32'(write), 32'd1);
         check_eq($sformatf("t3_c%0d_addr", k),  address, 32'h00001000);
         check_eq($sformatf("t3_c%0d_be", k),    32'(byteenable), 32'h3);
         check_eq($sformatf("t3_c%0d_wdata", k), writedata, 32'hAABBCCDD);
         check_eq($sformatf("t3_c%0d_dwait", k), 32'(d_waitrequest), 32'd1);
      end
      cyc(); settle();
      check_eq("t3_resp_write",  32'(write), 32'd0);
      check_eq("t3_resp_dwait",  32'(d_waitrequest), 32'd0);
      check_eq("t3_resp_drdata", d_readdata, 32'h11111111);
      check_eq("t3_resp_tmo",    32'(bus_timeout), 32'd0);
      d_write = 1'b0;
      cyc(); settle();
      check_eq("t3_idle_busy", 32'(busy), 32'd0);

      // Watchdog: eight stalled cycles set the sticky flag
      i_read = 1'b1; i_address = 32'h00000040; waitrequest = 1'b1; readdata = 32'h5A5A5A5A;
      for (int k = 1; k <= 9; k++) begin
         cyc(); settle();
         if (k == 8) check_eq("t4_c8_tmo", 32'(bus_timeout), 32'd0);
         if (k == 9) check_eq("t4_c9_tmo", 32'(bus_timeout), 32'd1);
      end
      cyc(); waitrequest = 1'b0; settle();
      check_eq("t4_c10_read", 32'(read), 32'd1);
      cyc(); settle();
      check_eq("t4_resp_iwait",  32'(i_waitrequest), 32'd0);
      check_eq("t4_resp_irdata", i_readdata, 32'h5A5A5A5A);
      i_read = 1'b0;
      cyc(); settle();
      check_eq("t4_idle_tmo", 32'(bus_timeout), 32'd1);

      // Illegal simultaneous read and write
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h00003000;
      d_byteenable = 4'hF; d_writedata = 32'h12345678;
      cyc(); settle();
      check_eq("t5_rw", {30'd0, read, write}, 32'd1);
      check_eq("t5_perr", 32'(protocol_error), 32'd1);
      cyc(); settle();
      check_eq("t5_dwait", 32'(d_waitrequest), 32'd0);
      d_read = 1'b0; d_write = 1'b0;
      cyc(); settle();
      check_eq("t5_perr_sticky", 32'(protocol_error), 32'd1);
      check_eq("t5_drdata",      d_readdata, 32'h11111111);

      // Reset in the middle of a stalled data write
      d_write = 1'b1; d_address = 32'h00005000; d_writedata = 32'h0BADBEEF; waitrequest = 1'b1;
      cyc(); settle();
      check_eq("t6_c1_write", 32'(write), 32'd1);
      cyc(); reset = 1'b1;
      cyc(); settle();
      check_eq("t6_rst_write", 32'(write), 32'd0);
      check_eq("t6_rst_busy",  32'(busy), 32'd0);
      check_eq("t6_rst_drd",   d_readdata, 32'd0);
      check_eq("t6_rst_flags", {30'd0, bus_timeout, protocol_error}, 32'd0);
      reset = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
      i_read = 1'b1; i_address = 32'h00000080; readdata = 32'hCAFEF00D;
      cyc(); settle();
      check_eq("t6_c1_read", 32'(read), 32'd1);
      check_eq("t6_c1_addr", address, 32'h00000080);
      cyc(); settle();
      check_eq("t6_c2_iwait",  32'(i_waitrequest), 32'd0);
      check_eq("t6_c2_irdata", i_readdata, 32'hCAFEF00D);
      i_read = 1'b0;
      cyc(); settle();
      check_eq("t6_c3_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
